// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-stage state encoding and the default NOP word.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } stage_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline register (main + skid, FIFO order) with registered ready
// and flush-to-NOP, replacing the per-stage IF/ID .. MEM/WB registers.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                PAYLOAD_W = 96,
  parameter int                CTRL_W    = 8,
  parameter int                INST_W    = 32,
  parameter logic [INST_W-1:0] NOP_INST  = INST_W'(NOP_INST_DEF)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [INST_W-1:0]    i_inst,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic [CTRL_W-1:0]    i_ctrl,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [INST_W-1:0]    o_inst,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic [CTRL_W-1:0]    o_ctrl,
  output logic [1:0]           o_occupancy
);

  localparam int ENT_W = INST_W + PAYLOAD_W + CTRL_W;

  stage_state_e     state;
  logic [ENT_W-1:0] main_q, skid_q;
  logic             valid_q, ready_q;
  logic [1:0]       occ_q;

  logic [ENT_W-1:0] in_ent;
  logic             in_xfer, out_xfer;

  assign in_ent   = {i_inst, i_payload, i_ctrl};
  assign in_xfer  = i_valid & ready_q;
  assign out_xfer = valid_q & i_ready;

  // valid/ready/occupancy are registered alongside the state so no output
  // ever sees a combinational path from i_ready.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      occ_q   <= 2'd0;
    end else if (i_flush) begin
      state   <= S_EMPTY;
      main_q  <= {NOP_INST, {PAYLOAD_W{1'b0}}, {CTRL_W{1'b0}}};
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
    end else begin
      case (state)
        S_EMPTY: begin
          ready_q <= 1'b1;
          if (in_xfer) begin
            main_q  <= in_ent;
            state   <= S_ONE;
            valid_q <= 1'b1;
            occ_q   <= 2'd1;
          end
        end
        S_ONE: begin
          case ({in_xfer, out_xfer})
            2'b11: main_q <= in_ent;
            2'b10: begin
              skid_q  <= in_ent;
              state   <= S_FULL;
              ready_q <= 1'b0;
              occ_q   <= 2'd2;
            end
            2'b01: begin
              state   <= S_EMPTY;
              valid_q <= 1'b0;
              occ_q   <= 2'd0;
            end
            default: ;
          endcase
        end
        S_FULL: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state   <= S_ONE;
            ready_q <= 1'b1;
            occ_q   <= 2'd1;
          end
        end
        default: begin
          state   <= S_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

  assign o_valid     = valid_q;
  assign o_ready     = ready_q;
  assign o_occupancy = occ_q;
  assign o_inst      = main_q[ENT_W-1 -: INST_W];
  assign o_payload   = main_q[CTRL_W +: PAYLOAD_W];
  assign o_ctrl      = main_q[CTRL_W-1:0];

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: vector table plus scoreboard model,
// with hand-written stream, flush and async-reset sequences.
module tb_pipe_skid_stage;
  localparam int PW = 96, CW = 8, IW = 32, EW = IW + PW + CW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          i_clk = 1'b0, i_reset = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic          o_ready, o_valid;
  logic [IW-1:0] i_inst = '0, o_inst;
  logic [PW-1:0] i_payload = '0, o_payload;
  logic [CW-1:0] i_ctrl = '0, o_ctrl;
  logic [1:0]    o_occupancy;

  pipe_skid_stage #(.PAYLOAD_W(PW), .CTRL_W(CW), .INST_W(IW), .NOP_INST(NOP)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_payload(i_payload), .i_ctrl(i_ctrl), .o_valid(o_valid), .i_ready(i_ready),
    .o_inst(o_inst), .o_payload(o_payload), .o_ctrl(o_ctrl), .o_occupancy(o_occupancy)
  );

  always #5 i_clk = ~i_clk;

  int            n_pass = 0, n_total = 0;
  logic [EW-1:0] q[$];
  logic [EW-1:0] last = '0;
  logic          m_ready = 1'b0;

  typedef struct {
    logic        v, r, f;
    logic [31:0] inst;
    logic [1:0]  exp_occ;
    logic        exp_ready;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] mk_ent(input logic [31:0] inst);
    logic [PW-1:0] p;
    logic [CW-1:0] c;
    p = {inst, ~inst, inst ^ 32'hA5A5_A5A5};
    c = inst[7:0] ^ 8'h5A;
    return {inst, p, c};
  endfunction

  task automatic check_all();
    chk("valid", 128'(o_valid), 128'(q.size() != 0));
    chk("ready", 128'(o_ready), 128'(m_ready));
    chk("occupancy", 128'(o_occupancy), 128'(q.size()));
    chk("inst", 128'(o_inst), 128'(last[EW-1 -: IW]));
    chk("payload", 128'(o_payload), 128'(last[CW +: PW]));
    chk("ctrl", 128'(o_ctrl), 128'(last[CW-1:0]));
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 1'b0;
    last = '0;
  endtask

  // Drive one cycle from just after a negedge; model advances at the posedge.
  task automatic cycle(input logic v, input logic r, input logic f, input logic [31:0] inst);
    logic [EW-1:0] e;
    logic in_x, out_x;
    e = mk_ent(inst);
    i_valid = v; i_ready = r; i_flush = f;
    i_inst = e[EW-1 -: IW]; i_payload = e[CW +: PW]; i_ctrl = e[CW-1:0];
    @(posedge i_clk);
    if (f) begin
      q.delete();
      m_ready = 1'b1;
      last = {NOP, {PW{1'b0}}, {CW{1'b0}}};
    end else begin
      in_x  = v && m_ready;
      out_x = (q.size() != 0) && r;
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(e);
      m_ready = (q.size() != 2);
    end
    if (q.size() != 0) last = q[0];
    @(negedge i_clk);
    check_all();
  endtask

  initial begin
    int seen;
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,          2'd0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0050_0093,  2'd1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,          2'd0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'hAAAA_0001,  2'd1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'hBBBB_0002,  2'd2, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'hCCCC_0003,  2'd2, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'hCCCC_0003,  2'd2, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'hCCCC_0003,  2'd1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'hCCCC_0003,  2'd1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,          2'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'hDDDD_0004,  2'd1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'hEEEE_0005,  2'd2, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_0006,  2'd0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,          2'd0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h1234_5678,  2'd1, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,          2'd0, 1'b1};

    model_reset();
    repeat (2) @(negedge i_clk);
    check_all();
    i_reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].v, vecs[i].r, vecs[i].f, vecs[i].inst);
      chk($sformatf("tbl%0d_occ", i), 128'(o_occupancy), 128'(vecs[i].exp_occ));
      chk($sformatf("tbl%0d_ready", i), 128'(o_ready), 128'(vecs[i].exp_ready));
    end

    // 8 back-to-back entries with downstream always ready: no bubbles
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h5000_0000 + 32'(i));
      if (o_valid) seen++;
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stream_valid_cycles", 128'(seen), 128'd8);
    chk("stream_drained", 128'(o_occupancy), 128'd0);

    // Fill to FULL, then assert reset mid-cycle: outputs clear before the next edge
    cycle(1'b1, 1'b0, 1'b0, 32'h7777_0001);
    cycle(1'b1, 1'b0, 1'b0, 32'h7777_0002);
    chk("pre_reset_full", 128'(o_occupancy), 128'd2);
    i_valid = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge i_clk);
    check_all();
    i_reset = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_A0B3);
    chk("post_reset_inst", 128'(o_inst), 128'(32'h0000_A0B3));
    cycle(1'b0, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The module SHALL have parameter PAYLOAD_W, default 96, meaning the width of the data payload (e.g. pc, alu_data, ld_data concatenated).
REQ-002 The module SHALL have parameter CTRL_W, default 8, meaning the width of the control bundle (e.g. wb_sel, rd_wren, pc_sel, rd_addr).
REQ-003 The module SHALL have parameter INST_W, default 32, meaning the width of the instruction field.
REQ-004 The module SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the instruction word injected on flush.
REQ-005 Ports SHALL be as follows; reset is i_reset, asynchronous, active-low; clock is i_clk.
- i_clk  in  1  clock
- i_reset  in  1  async active-low reset
- i_flush  in  1  synchronous clear of all held entries
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept an entry this cycle
- i_inst  in  INST_W  upstream instruction
- i_payload  in  PAYLOAD_W  upstream data
- i_ctrl  in  CTRL_W  upstream control
- o_valid  out  1  output entry valid
- i_ready  in  1  downstream accepts output this cycle
- o_inst  out  INST_W  held instruction
- o_payload  out  PAYLOAD_W  held data
- o_ctrl  out  CTRL_W  held control
- o_occupancy  out  2  entries held (0..2)

Function
REQ-006 The stage SHALL hold up to two entries: a main (output) register and a skid register, ordered FIFO.
REQ-007 An input transfer SHALL occur when i_valid and o_ready are both 1 at a rising edge; an output transfer SHALL occur when o_valid and i_ready are both 1.
REQ-008 The state machine SHALL have states EMPTY (occupancy 0), ONE (1) and FULL (2).
REQ-009 In EMPTY, an input transfer SHALL load the main register and go to ONE; o_valid SHALL rise one cycle after acceptance.
REQ-010 In ONE, input and output together SHALL reload main and stay in ONE; input only SHALL load skid and go to FULL; output only SHALL go to EMPTY.
REQ-011 In FULL, an output transfer SHALL move skid to main and go to ONE; input is not accepted in FULL.
REQ-012 o_ready SHALL be a registered signal equal to (state != FULL); it SHALL NOT depend combinationally on i_ready.
REQ-013 While o_valid=1 and i_ready=0, o_inst, o_payload and o_ctrl SHALL remain stable.
REQ-014 Sustained i_valid=i_ready=1 SHALL give one transfer per cycle with 1-cycle latency.
REQ-015 o_valid SHALL equal (state != EMPTY); o_occupancy SHALL be 0, 1 or 2 according to the state.
REQ-016 i_flush=1 SHALL, at the next edge, go to EMPTY and set o_inst=NOP_INST, o_payload=0, o_ctrl=0 and o_valid=0, discarding the skid contents.
REQ-017 i_flush SHALL take priority over a simultaneous input or output transfer; the input entry is dropped.
REQ-018 o_ready SHALL be 1 in the cycle after a flush.
REQ-019 In EMPTY, o_inst, o_payload and o_ctrl SHALL keep their last values (post-flush: NOP/0/0); consumers qualify them with o_valid.

Reset
REQ-020 While i_reset=0, the stage SHALL be in EMPTY with o_valid=0, o_ready=0, o_occupancy=0, o_inst=0, o_payload=0, o_ctrl=0 and skid=0.
REQ-021 o_ready SHALL become 1 at the first clock edge after reset release.
REQ-022 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-023 The state enum (EMPTY/ONE/FULL) and the default NOP_INST constant SHALL be defined in the shared package pipe_pkg.
REQ-024 The stage SHALL be a single module with no sub-modules; multiple instances SHALL replace the per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Verification
REQ-025 Reset release, then i_valid=1 with i_inst=0x00500093 and i_ready=1 -> o_valid=1 with o_inst=0x00500093 one cycle later; occupancy=1.
REQ-026 Stream entries A,B,C with i_ready=0 -> A and B are accepted, o_ready=0 and occupancy=2, C is held; raise i_ready -> A, B, C emerge in order on consecutive cycles.
REQ-027 Continuous stream of 8 entries with i_ready=1 -> 8 outputs in 8 cycles with no bubble.
REQ-028 From FULL, i_flush=1 together with i_valid=1 -> next cycle o_valid=0, o_inst=0x00000013, o_ctrl=0, occupancy=0, o_ready=1; the input is not emitted.
REQ-029 Assert i_reset=0 mid-cycle while in FULL -> outputs go to reset values before the next edge; after release, the first accepted entry is output correctly.
